// File: rtl/soc_l2_bank_arbiter_pkg.sv
// Shared interconnect definitions for the contiguous L2 path.
// Holds constants common to L2 bank arbiters and slaves.
package pkg_soc_interconnect;

    // Cycles from bank handshake to bank response.
    localparam int L2_BANK_RESP_LATENCY = 1;

endpackage

// File: rtl/soc_l2_rr_pick.sv
// Round-robin pick: first set bit at or after ptr_i, wrapping.
// Ports: req_i (request vector), ptr_i (start index),
//        valid_o (any request), idx_o (picked index).
module soc_l2_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic w_found;

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_i[(int'(ptr_i) + k) % N]) begin
                w_found = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/soc_l2_bank_arbiter.sv
// Shares one single-ported L2 bank between NR_MASTERS TCDM requesters.
// Ports: mst_* master side, slv_* bank side, resp_err_o sticky spurious-response flag.
module soc_l2_bank_arbiter
    import pkg_soc_interconnect::*;
#(
    parameter int NR_MASTERS   = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int HIPRIO_IDX   = 0,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NR_MASTERS-1:0]                  mst_req_i,
    input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]  mst_add_i,
    input  logic [NR_MASTERS-1:0]                  mst_wen_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]  mst_wdata_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0] mst_be_i,
    output logic [NR_MASTERS-1:0]                  mst_gnt_o,
    output logic [NR_MASTERS-1:0]                  mst_r_valid_o,
    output logic [DATA_WIDTH-1:0]                  mst_r_rdata_o,
    output logic                                   slv_req_o,
    output logic [ADDR_WIDTH-1:0]                  slv_add_o,
    output logic                                   slv_wen_o,
    output logic [DATA_WIDTH-1:0]                  slv_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                slv_be_o,
    input  logic                                   slv_gnt_i,
    input  logic                                   slv_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                  slv_r_rdata_i,
    output logic                                   resp_err_o
);

    typedef logic [$clog2(NR_MASTERS)-1:0] arb_idx_t;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef logic [CW-1:0] cnt_t;

    arb_idx_t                  r_rr_ptr;
    arb_idx_t                  r_resp_idx;
    logic                      r_resp_pend;
    logic                      r_err;
    logic [NR_MASTERS-1:0][CW-1:0] r_wait;

    arb_idx_t w_rr_idx;
    arb_idx_t w_starve_idx;
    arb_idx_t w_win;
    logic     w_rr_vld;
    logic     w_starve_vld;
    logic     w_from_rr;
    logic     w_any;
    logic     w_hs;

    soc_l2_rr_pick #(
        .N (NR_MASTERS)
    ) u_rr_pick (
        .req_i   (mst_req_i),
        .ptr_i   (r_rr_ptr),
        .valid_o (w_rr_vld),
        .idx_o   (w_rr_idx)
    );

    // Descending scan so the lowest starving index wins.
    always_comb begin
        w_starve_vld = 1'b0;
        w_starve_idx = '0;
        for (int i = NR_MASTERS - 1; i >= 0; i--) begin
            if (i != HIPRIO_IDX && mst_req_i[i] &&
                r_wait[i] == cnt_t'(STARVE_LIMIT)) begin
                w_starve_vld = 1'b1;
                w_starve_idx = arb_idx_t'(i);
            end
        end
    end

    always_comb begin
        w_win     = w_rr_idx;
        w_from_rr = 1'b0;
        priority case (1'b1)
            w_starve_vld:          w_win = w_starve_idx;
            mst_req_i[HIPRIO_IDX]: w_win = arb_idx_t'(HIPRIO_IDX);
            default:               w_from_rr = w_rr_vld;
        endcase
    end

    assign w_any     = |mst_req_i;
    assign w_hs      = w_any & slv_gnt_i;
    assign slv_req_o = w_any;

    always_comb begin
        slv_add_o   = '0;
        slv_wen_o   = 1'b0;
        slv_wdata_o = '0;
        slv_be_o    = '0;
        mst_gnt_o   = '0;
        if (w_any) begin
            slv_add_o   = mst_add_i[w_win];
            slv_wen_o   = mst_wen_i[w_win];
            slv_wdata_o = mst_wdata_i[w_win];
            slv_be_o    = mst_be_i[w_win];
        end
        if (w_hs) begin
            mst_gnt_o[w_win] = 1'b1;
        end
    end

    always_comb begin
        mst_r_valid_o = '0;
        if (slv_r_valid_i && r_resp_pend) begin
            mst_r_valid_o[r_resp_idx] = 1'b1;
        end
    end

    assign mst_r_rdata_o = slv_r_rdata_i;
    assign resp_err_o    = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr    <= '0;
            r_resp_idx  <= '0;
            r_resp_pend <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_resp_pend <= w_hs;
            if (w_hs) begin
                r_resp_idx <= w_win;
                if (w_from_rr) begin
                    r_rr_ptr <= (int'(w_win) == NR_MASTERS - 1) ?
                                '0 : w_win + 1'b1;
                end
            end
            if (slv_r_valid_i && !r_resp_pend) begin
                r_err <= 1'b1;
            end
        end
    end

    // High-priority master never accumulates wait; it cannot starve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < NR_MASTERS; i++) begin
                if (i == HIPRIO_IDX || !mst_req_i[i] ||
                    (w_hs && int'(w_win) == i)) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != cnt_t'(STARVE_LIMIT)) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_l2_bank_arbiter.sv
// Self-checking bench for soc_l2_bank_arbiter.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_soc_l2_bank_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int HP = 0;
    localparam int SL = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]         t_req;
    logic [NR-1:0][AW-1:0] t_add;
    logic [NR-1:0]         t_wen;
    logic [NR-1:0][DW-1:0] t_wdata;
    logic [NR-1:0][BW-1:0] t_be;
    logic                  t_gnt;
    logic                  t_rv;
    logic [DW-1:0]         t_rdata;

    logic [NR-1:0] mst_gnt;
    logic [NR-1:0] mst_rv;
    logic [DW-1:0] mst_rdata;
    logic          slv_req;
    logic [AW-1:0] slv_add;
    logic          slv_wen;
    logic [DW-1:0] slv_wdata;
    logic [BW-1:0] slv_be;
    logic          resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int            m_ptr;
    int            m_wait [NR];
    bit            m_pend;
    int            m_idx;
    bit            m_err;
    logic [NR-1:0] m_gmask;

    always #5 clk = ~clk;

    soc_l2_bank_arbiter #(
        .NR_MASTERS   (NR),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .HIPRIO_IDX   (HP),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mst_req_i     (t_req),
        .mst_add_i     (t_add),
        .mst_wen_i     (t_wen),
        .mst_wdata_i   (t_wdata),
        .mst_be_i      (t_be),
        .mst_gnt_o     (mst_gnt),
        .mst_r_valid_o (mst_rv),
        .mst_r_rdata_o (mst_rdata),
        .slv_req_o     (slv_req),
        .slv_add_o     (slv_add),
        .slv_wen_o     (slv_wen),
        .slv_wdata_o   (slv_wdata),
        .slv_be_o      (slv_be),
        .slv_gnt_i     (t_gnt),
        .slv_r_valid_i (t_rv),
        .slv_r_rdata_i (t_rdata),
        .resp_err_o    (resp_err)
    );

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) m_wait[i] = 0;
        m_pend  = 0;
        m_idx   = 0;
        m_err   = 0;
        m_gmask = '0;
    endtask

    // Winner by the arbitration rules: starving, then high priority, then round-robin.
    function automatic int m_pick(input logic [NR-1:0] r, output bit by_rr);
        by_rr = 0;
        for (int i = 0; i < NR; i++)
            if (i != HP && r[i] && m_wait[i] >= SL) return i;
        if (r[HP]) return HP;
        for (int k = 0; k < NR; k++)
            if (r[(m_ptr + k) % NR]) begin
                by_rr = 1;
                return (m_ptr + k) % NR;
            end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_gnt(input logic [NR-1:0] r, input logic g);
        logic [NR-1:0] v;
        int w;
        bit b;
        v = '0;
        w = m_pick(r, b);
        if (w >= 0 && g) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [NR-1:0] exp_rv(input logic rv);
        logic [NR-1:0] v;
        v = '0;
        if (rv && m_pend) v[m_idx] = 1'b1;
        return v;
    endfunction

    task automatic m_tick(input logic [NR-1:0] r, input logic g, input logic rv);
        int w;
        bit b;
        bit hs;
        w  = m_pick(r, b);
        hs = (w >= 0) && g;
        if (rv && !m_pend) m_err = 1;
        for (int i = 0; i < NR; i++) begin
            if (i == HP || !r[i] || (hs && w == i)) m_wait[i] = 0;
            else if (m_wait[i] < SL) m_wait[i]++;
        end
        m_gmask = '0;
        if (hs) begin
            m_gmask[w] = 1'b1;
            if (b) m_ptr = (w + 1) % NR;
            m_pend = 1;
            m_idx  = w;
        end else begin
            m_pend = 0;
        end
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic g,
                         input logic rv, input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        t_req   = r;
        t_gnt   = g;
        t_rv    = rv;
        t_rdata = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        t_req   = '0;
        t_gnt   = 1'b0;
        t_rv    = 1'b0;
        t_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({mst_gnt, mst_rv, slv_req, slv_add, slv_wen, slv_wdata, slv_be, resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b rv=%b req=%b add=%h err=%b required all 0",
                     mst_gnt, mst_rv, slv_req, slv_add, resp_err);
        end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{1, 2, 3, 1, 2, 3};
        logic [NR-1:0] e;
        logic rv;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rv = m_pend;
            drive((c < 6) ? 4'b1110 : 4'b0000, 1'b1, rv, DW'($urandom));
            e = '0;
            if (c < 6) e[seq[c]] = 1'b1;
            n_tests++;
            if (mst_gnt !== e || e !== exp_gnt(t_req, t_gnt)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b required %b", c, mst_gnt, e);
            end
            n_tests++;
            if (mst_rv !== exp_rv(rv)) begin
                n_fail++;
                $display("FAIL rr_rvalid[%0d]: got %b required %b", c, mst_rv, exp_rv(rv));
            end
            m_tick(t_req, t_gnt, rv);
        end
    endtask

    task automatic test_starvation();
        logic [NR-1:0] e;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            drive(4'b0101, 1'b1, m_pend, '0);
            e = (c == 8) ? 4'b0100 : 4'b0001;
            n_tests++;
            if (mst_gnt !== e || e !== exp_gnt(t_req, t_gnt)) begin
                n_fail++;
                $display("FAIL starve_grant[cycle %0d]: got %b required %b", c, mst_gnt, e);
            end
            m_tick(t_req, t_gnt, t_rv);
        end
    endtask

    task automatic test_stall();
        // Masters 1 and 3 wait through the stall; a pointer that moved early would pick 3.
        for (int c = 0; c < 5; c++) begin
            drive(4'b1010, 1'b0, m_pend, '0);
            n_tests++;
            if (mst_gnt !== 4'b0000 || slv_req !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_grant[%0d]: gnt=%b req=%b required 0000/1", c, mst_gnt, slv_req);
            end
            m_tick(t_req, t_gnt, t_rv);
        end
        drive(4'b1010, 1'b1, m_pend, '0);
        n_tests++;
        if (mst_gnt !== 4'b0010 || mst_gnt !== exp_gnt(t_req, t_gnt)) begin
            n_fail++;
            $display("FAIL stall_release: got %b required 0010", mst_gnt);
        end
        m_tick(t_req, t_gnt, t_rv);
        drive(4'b1000, 1'b1, m_pend, '0);
        m_tick(t_req, t_gnt, t_rv);
    endtask

    task automatic test_read_routing();
        t_add[3]   = 32'h1C00_0010;
        t_wen[3]   = 1'b1;
        t_wdata[3] = 32'h0;
        t_be[3]    = 4'hF;
        drive(4'b1000, 1'b1, m_pend, '0);
        n_tests++;
        if (mst_gnt !== 4'b1000 || slv_add !== 32'h1C00_0010 || slv_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL route_req: gnt=%b add=%h wen=%b required 1000/1c000010/1",
                     mst_gnt, slv_add, slv_wen);
        end
        m_tick(t_req, t_gnt, t_rv);
        drive(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
        n_tests++;
        if (mst_rv !== 4'b1000 || mst_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL route_resp: rv=%b rdata=%h required 1000/deadbeef", mst_rv, mst_rdata);
        end
        m_tick(t_req, t_gnt, t_rv);
    endtask

    task automatic test_spurious();
        do_reset();
        drive(4'b0000, 1'b1, 1'b1, 32'h1234_5678);
        n_tests++;
        if (mst_rv !== 4'b0000) begin
            n_fail++;
            $display("FAIL spurious_rvalid: got %b required 0000", mst_rv);
        end
        m_tick(t_req, t_gnt, t_rv);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 1'b1, 1'b0, '0);
            n_tests++;
            if (resp_err !== 1'b1 || m_err !== 1'b1) begin
                n_fail++;
                $display("FAIL spurious_err[%0d]: got %b required 1", c, resp_err);
            end
            m_tick(t_req, t_gnt, t_rv);
        end
        do_reset();
        n_tests++;
        if (resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_err_reset: got %b required 0", resp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] e;
        do_reset();
        drive(4'b0010, 1'b1, m_pend, '0);
        m_tick(t_req, t_gnt, t_rv);
        for (int c = 0; c < 5; c++) begin
            drive(4'b1001, 1'b1, m_pend, '0);
            m_tick(t_req, t_gnt, t_rv);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        t_req = '0;
        t_rv  = 1'b1;
        #1;
        n_tests++;
        if (mst_rv !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_rvalid: got %b required 0000", mst_rv);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (resp_err !== 1'b0 || mst_rv !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_hold: err=%b rv=%b required 0/0000", resp_err, mst_rv);
        end
        @(negedge clk);
        t_rv  = 1'b0;
        rst_n = 1'b1;
        model_reset();
        drive(4'b1010, 1'b1, 1'b0, '0);
        n_tests++;
        if (mst_gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_ptr: got %b required 0010", mst_gnt);
        end
        m_tick(t_req, t_gnt, t_rv);
        for (int c = 0; c < 8; c++) begin
            drive(4'b1001, 1'b1, m_pend, '0);
            e = exp_gnt(t_req, t_gnt);
            n_tests++;
            if (mst_gnt !== e) begin
                n_fail++;
                $display("FAIL midreset_cnt[%0d]: got %b required %b", c, mst_gnt, e);
            end
            m_tick(t_req, t_gnt, t_rv);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] e;
        logic [NR-1:0] erv;
        logic [AW-1:0] eadd;
        logic [DW-1:0] ewd;
        logic [BW-1:0] ebe;
        logic          ewen;
        int w;
        bit b;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!t_req[i] || m_gmask[i]) begin
                    t_req[i] = ($urandom_range(0, 2) != 0);
                    t_add[i]   = $urandom;
                    t_wen[i]   = $urandom_range(0, 1);
                    t_wdata[i] = $urandom;
                    t_be[i]    = BW'($urandom);
                end
            end
            t_gnt   = ($urandom_range(0, 4) != 0);
            t_rv    = m_pend;
            t_rdata = $urandom;
            @(negedge clk);
            e   = exp_gnt(t_req, t_gnt);
            erv = exp_rv(t_rv);
            w   = m_pick(t_req, b);
            eadd = '0; ewen = 1'b0; ewd = '0; ebe = '0;
            if (w >= 0) begin
                eadd = t_add[w];
                ewen = t_wen[w];
                ewd  = t_wdata[w];
                ebe  = t_be[w];
            end
            n_tests++;
            if (mst_gnt !== e) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %b required %b", c, mst_gnt, e);
            end
            n_tests++;
            if ({slv_req, slv_add, slv_wen, slv_wdata, slv_be} !== {|t_req, eadd, ewen, ewd, ebe}) begin
                n_fail++;
                $display("FAIL rand_payload[%0d]: req=%b add=%h got winner payload, required req=%b add=%h",
                         c, slv_req, slv_add, |t_req, eadd);
            end
            n_tests++;
            if (mst_rv !== erv || mst_rdata !== t_rdata || resp_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: rv=%b err=%b required rv=%b err=%b",
                         c, mst_rv, resp_err, erv, m_err);
            end
            m_tick(t_req, t_gnt, t_rv);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        t_req   = '0;
        t_add   = '0;
        t_wen   = '0;
        t_wdata = '0;
        t_be    = '0;
        t_gnt   = 1'b0;
        t_rv    = 1'b0;
        t_rdata = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_stall();
        test_starvation();
        test_read_routing();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
